// File: rtl/tap_pkg.sv
// Shared TAP types: the 16 controller states with their standard 4-bit codes,
// plus default instruction-register width, BYPASS opcode and capture pattern.
package tap_pkg;

  typedef enum logic [3:0] {
    S_EXIT2_DR         = 4'h0,
    S_EXIT1_DR         = 4'h1,
    S_SHIFT_DR         = 4'h2,
    S_PAUSE_DR         = 4'h3,
    S_SELECT_IR_SCAN   = 4'h4,
    S_UPDATE_DR        = 4'h5,
    S_CAPTURE_DR       = 4'h6,
    S_SELECT_DR_SCAN   = 4'h7,
    S_EXIT2_IR         = 4'h8,
    S_EXIT1_IR         = 4'h9,
    S_SHIFT_IR         = 4'hA,
    S_PAUSE_IR         = 4'hB,
    S_RUN_TEST_IDLE    = 4'hC,
    S_UPDATE_IR        = 4'hD,
    S_CAPTURE_IR       = 4'hE,
    S_TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam int             DEF_IR_W       = 4;
  localparam logic [DEF_IR_W-1:0] DEF_BYPASS_OP  = 4'hF;
  localparam logic [DEF_IR_W-1:0] DEF_IR_CAPTURE = 4'b0001;

endpackage

// File: rtl/tap_controller_if.sv
// Pin-side and DR-side signals of the TAP controller, bundled for port passing.
interface tap_controller_if
  import tap_pkg::*;
#(
  parameter int IR_W = DEF_IR_W
);

  // TMS/TDI are sampled on rising TCK; TDO/TDO_en launch on falling TCK.
  // Strobes, ir_out, sel_bypass, tlr and state change only after rising TCK.
  logic            TMS;
  logic            TDI;
  logic            bypass_tdo;
  logic            dr_tdo;
  logic            TDO;
  logic            TDO_en;
  logic            Capture_DR;
  logic            Shift_DR;
  logic            Update_DR;
  logic [IR_W-1:0] ir_out;
  logic            sel_bypass;
  logic            tlr;
  tap_state_t      state;

  modport master (
    output TMS, TDI, bypass_tdo, dr_tdo,
    input  TDO, TDO_en, Capture_DR, Shift_DR, Update_DR,
    input  ir_out, sel_bypass, tlr, state
  );

  modport slave (
    input  TMS, TDI, bypass_tdo, dr_tdo,
    output TDO, TDO_en, Capture_DR, Shift_DR, Update_DR,
    output ir_out, sel_bypass, tlr, state
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP state machine: state register and TMS-driven next-state logic.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  output tap_state_t state,
  output logic       tlr
);

  function automatic tap_state_t next_state(input tap_state_t s, input logic m);
    tap_state_t n;
    n = S_TEST_LOGIC_RESET;
    case (s)
      S_TEST_LOGIC_RESET: n = m ? S_TEST_LOGIC_RESET : S_RUN_TEST_IDLE;
      S_RUN_TEST_IDLE:    n = m ? S_SELECT_DR_SCAN   : S_RUN_TEST_IDLE;
      S_SELECT_DR_SCAN:   n = m ? S_SELECT_IR_SCAN   : S_CAPTURE_DR;
      S_CAPTURE_DR:       n = m ? S_EXIT1_DR         : S_SHIFT_DR;
      S_SHIFT_DR:         n = m ? S_EXIT1_DR         : S_SHIFT_DR;
      S_EXIT1_DR:         n = m ? S_UPDATE_DR        : S_PAUSE_DR;
      S_PAUSE_DR:         n = m ? S_EXIT2_DR         : S_PAUSE_DR;
      S_EXIT2_DR:         n = m ? S_UPDATE_DR        : S_SHIFT_DR;
      S_UPDATE_DR:        n = m ? S_SELECT_DR_SCAN   : S_RUN_TEST_IDLE;
      S_SELECT_IR_SCAN:   n = m ? S_TEST_LOGIC_RESET : S_CAPTURE_IR;
      S_CAPTURE_IR:       n = m ? S_EXIT1_IR         : S_SHIFT_IR;
      S_SHIFT_IR:         n = m ? S_EXIT1_IR         : S_SHIFT_IR;
      S_EXIT1_IR:         n = m ? S_UPDATE_IR        : S_PAUSE_IR;
      S_PAUSE_IR:         n = m ? S_EXIT2_IR         : S_PAUSE_IR;
      S_EXIT2_IR:         n = m ? S_UPDATE_IR        : S_SHIFT_IR;
      S_UPDATE_IR:        n = m ? S_SELECT_DR_SCAN   : S_RUN_TEST_IDLE;
      default:            n = S_TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

  // tlr is registered alongside state so it never glitches on the pad side.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      state <= S_TEST_LOGIC_RESET;
      tlr   <= 1'b1;
    end else begin
      state <= next_state(state, TMS);
      tlr   <= (next_state(state, TMS) == S_TEST_LOGIC_RESET);
    end
  end

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: FSM, instruction register, DR strobes and falling-edge
// TDO stage selecting between the IR, the bypass bit and the other DR path.
module tap_controller
  import tap_pkg::*;
#(
  parameter int              IR_W       = DEF_IR_W,
  parameter logic [IR_W-1:0] BYPASS_OP  = (IR_W == DEF_IR_W) ? IR_W'(DEF_BYPASS_OP) : '1,
  parameter logic [IR_W-1:0] IR_CAPTURE = IR_W'(DEF_IR_CAPTURE)
) (
  input logic              TCK,
  input logic              TRST_n,
  tap_controller_if.slave  bus
);

  tap_state_t      state;
  logic            tlr;
  logic [IR_W-1:0] ir_sh;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_cur;
  logic            sel_bypass;
  logic            tdo_q;
  logic            tdo_en_q;

  tap_fsm u_fsm (
    .TCK    (TCK),
    .TRST_n (TRST_n),
    .TMS    (bus.TMS),
    .state  (state),
    .tlr    (tlr)
  );

  // ir_out only ever takes a whole ir_sh word, so an aborted shift leaves it intact.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_sh <= IR_CAPTURE;
      ir_q  <= BYPASS_OP;
    end else begin
      case (state)
        S_CAPTURE_IR:       ir_sh <= IR_CAPTURE;
        S_SHIFT_IR:         ir_sh <= {bus.TDI, ir_sh[IR_W-1:1]};
        S_UPDATE_IR:        ir_q  <= ir_sh;
        S_TEST_LOGIC_RESET: ir_q  <= BYPASS_OP;
        default:            ;
      endcase
    end
  end

  // Masking in TLR makes BYPASS visible from the first cycle in that state.
  assign ir_cur     = (state == S_TEST_LOGIC_RESET) ? BYPASS_OP : ir_q;
  assign sel_bypass = (ir_cur == BYPASS_OP);

  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      case (state)
        S_SHIFT_IR: begin
          tdo_q    <= ir_sh[0];
          tdo_en_q <= 1'b1;
        end
        S_SHIFT_DR: begin
          tdo_q    <= sel_bypass ? bus.bypass_tdo : bus.dr_tdo;
          tdo_en_q <= 1'b1;
        end
        default: begin
          tdo_q    <= 1'b0;
          tdo_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Capture_DR = (state == S_CAPTURE_DR);
  assign bus.Shift_DR   = (state == S_SHIFT_DR);
  assign bus.Update_DR  = (state == S_UPDATE_DR);
  assign bus.ir_out     = ir_cur;
  assign bus.sel_bypass = sel_bypass;
  assign bus.tlr        = tlr;
  assign bus.state      = state;
  assign bus.TDO        = tdo_q;
  assign bus.TDO_en     = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed TMS/TDI scans against a state-kind model
// checked every falling edge, plus hand-computed literal expectations.
module tb_tap_controller;
  import tap_pkg::*;

  localparam int W = 4;
  localparam logic [W-1:0] BYP = 4'hF;

  logic TCK    = 1'b0;
  logic TRST_n = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  tap_controller_if #(.IR_W(W)) bus ();

  tap_controller #(.IR_W(W)) dut (
    .TCK    (TCK),
    .TRST_n (TRST_n),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  always #5 TCK = ~TCK;

  // Stand-in for the downstream Bypass_reg.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n)             bus.bypass_tdo <= 1'b0;
    else if (bus.Capture_DR) bus.bypass_tdo <= 1'b0;
    else if (bus.Shift_DR)   bus.bypass_tdo <= bus.TDI;
  end

  // ---------------- model ----------------
  // State is kept as a (kind, ir-branch) pair; the IR branch mirrors the DR one.
  typedef enum int {K_TLR, K_RTI, K_SEL, K_CAP, K_SH, K_EX1, K_PAU, K_EX2, K_UPD} kind_t;
  kind_t          m_kind = K_TLR;
  bit             m_irb  = 1'b0;
  logic [W-1:0]   m_irsh = 4'b0001;
  logic [W-1:0]   m_ir   = 4'hF;
  logic           m_byp  = 1'b0;

  function automatic logic [3:0] ieee_code(input kind_t k, input bit irb);
    logic [3:0] c;
    c = 4'h0;
    case (k)
      K_TLR: c = 4'hF;
      K_RTI: c = 4'hC;
      K_SEL: c = irb ? 4'h4 : 4'h7;
      K_CAP: c = 4'h6;
      K_SH:  c = 4'h2;
      K_EX1: c = 4'h1;
      K_PAU: c = 4'h3;
      K_EX2: c = 4'h0;
      K_UPD: c = 4'h5;
      default: c = 4'h0;
    endcase
    if (irb && k != K_TLR && k != K_RTI && k != K_SEL) c = c + 4'h8;
    return c;
  endfunction

  always @(posedge TCK or negedge TRST_n) begin
    logic tms;
    if (!TRST_n) begin
      m_kind = K_TLR; m_irb = 1'b0; m_irsh = 4'b0001; m_ir = BYP; m_byp = 1'b0;
    end else begin
      tms = bus.TMS;
      if (m_irb) begin
        if (m_kind == K_CAP) m_irsh = 4'b0001;
        if (m_kind == K_SH)  m_irsh = m_irsh / 2 + (bus.TDI ? 4'h8 : 4'h0);
        if (m_kind == K_UPD) m_ir = m_irsh;
      end else begin
        if (m_kind == K_CAP) m_byp = 1'b0;
        if (m_kind == K_SH)  m_byp = bus.TDI;
      end
      if (m_kind == K_TLR) m_ir = BYP;
      case (m_kind)
        K_TLR: if (!tms) m_kind = K_RTI;
        K_RTI: if (tms) begin m_kind = K_SEL; m_irb = 1'b0; end
        K_SEL: begin
          if (!tms)       m_kind = K_CAP;
          else if (m_irb) begin m_kind = K_TLR; m_irb = 1'b0; end
          else            m_irb = 1'b1;
        end
        K_CAP, K_SH: m_kind = tms ? K_EX1 : K_SH;
        K_EX1: m_kind = tms ? K_UPD : K_PAU;
        K_PAU: if (tms) m_kind = K_EX2;
        K_EX2: m_kind = tms ? K_UPD : K_SH;
        K_UPD: begin m_irb = 1'b0; m_kind = tms ? K_SEL : K_RTI; end
        default: m_kind = K_TLR;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] exp_ir;
    logic         exp_en;
    logic         exp_tdo;
    exp_ir  = (m_kind == K_TLR) ? BYP : m_ir;
    exp_en  = (m_kind == K_SH);
    exp_tdo = 1'b0;
    if (exp_en) exp_tdo = m_irb ? m_irsh[0] : ((exp_ir == BYP) ? m_byp : bus.dr_tdo);
    chk4("state",      bus.state,      ieee_code(m_kind, m_irb));
    chk1("tlr",        bus.tlr,        m_kind == K_TLR);
    chk1("capture_dr", bus.Capture_DR, m_kind == K_CAP && !m_irb);
    chk1("shift_dr",   bus.Shift_DR,   m_kind == K_SH && !m_irb);
    chk1("update_dr",  bus.Update_DR,  m_kind == K_UPD && !m_irb);
    chk4("ir_out",     bus.ir_out,     exp_ir);
    chk1("sel_bypass", bus.sel_bypass, exp_ir == BYP);
    chk1("tdo_en",     bus.TDO_en,     exp_en);
    chk1("tdo",        bus.TDO,        exp_tdo);
  endtask

  always @(negedge TCK) begin
    #1;
    compare_all();
  end

  // ---------------- driver ----------------
  task automatic tick(input logic tms, input logic tdi);
    bus.TMS = tms;
    bus.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #2;
  endtask

  task automatic load_ir(input logic [3:0] v);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] pat;
    logic [3:0] strobe_tms;
    int cap_n, sh_n, upd_n;
    logic [8:0] path;
    bus.TMS = 1'b1; bus.TDI = 1'b0; bus.dr_tdo = 1'b0;

    #1 TRST_n = 1'b0;
    #1;
    chk4("rst_state", bus.state, 4'hF);
    chk1("rst_tlr", bus.tlr, 1'b1);
    chk1("rst_tdo_en", bus.TDO_en, 1'b0);
    chk1("rst_tdo", bus.TDO, 1'b0);
    chk4("rst_ir_out", bus.ir_out, 4'hF);
    chk1("rst_sel_bypass", bus.sel_bypass, 1'b1);
    chk1("rst_capture", bus.Capture_DR, 1'b0);
    chk1("rst_shift", bus.Shift_DR, 1'b0);
    chk1("rst_update", bus.Update_DR, 1'b0);
    @(negedge TCK); @(negedge TCK); #2;
    TRST_n = 1'b1;

    tick(1'b0, 1'b0);
    chk4("to_rti", bus.state, 4'hC);

    // IR capture scan-out: 1,0,0,0
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk4("shir_state", bus.state, 4'hA);
    chk1("ir_tdo0", bus.TDO, 1'b1);
    chk1("ir_en0", bus.TDO_en, 1'b1);
    tick(1'b0, 1'b0); chk1("ir_tdo1", bus.TDO, 1'b0);
    tick(1'b0, 1'b0); chk1("ir_tdo2", bus.TDO, 1'b0);
    tick(1'b0, 1'b0); chk1("ir_tdo3", bus.TDO, 1'b0);
    chk1("ir_en3", bus.TDO_en, 1'b1);
    tick(1'b1, 1'b0);
    chk1("ir_en_exit", bus.TDO_en, 1'b0);
    chk4("ex1ir_state", bus.state, 4'h9);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk4("ir_zero", bus.ir_out, 4'h0);

    load_ir(4'h2);
    chk4("ir_two", bus.ir_out, 4'h2);
    chk1("ir_two_sel", bus.sel_bypass, 1'b0);

    // dr_tdo routed while IR selects a non-bypass register
    pat = 4'b1101;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.dr_tdo = pat[i];
      tick(1'b0, 1'b0);
      chk1("dr_route", bus.TDO, pat[i]);
    end
    bus.dr_tdo = 1'b0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);

    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk4("sync_rst_state", bus.state, 4'hF);
    chk1("sync_rst_tlr", bus.tlr, 1'b1);
    chk4("sync_rst_ir", bus.ir_out, 4'hF);
    tick(1'b0, 1'b0);

    // bypass: TDI 1,0,1,1 -> TDO 0,1,0,1
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk1("byp_tdo0", bus.TDO, 1'b0);
    chk1("byp_en0", bus.TDO_en, 1'b1);
    tick(1'b0, 1'b1); chk1("byp_tdo1", bus.TDO, 1'b1);
    tick(1'b0, 1'b0); chk1("byp_tdo2", bus.TDO, 1'b0);
    tick(1'b0, 1'b1); chk1("byp_tdo3", bus.TDO, 1'b1);
    tick(1'b1, 1'b1); chk1("byp_en_exit", bus.TDO_en, 1'b0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);

    // full DR path through Pause-DR
    path = 9'b0_1101_0010; // TMS applied LSB first: 0,1,0,0,1,0,1,1,0
    cap_n = 0; sh_n = 0; upd_n = 0;
    strobe_tms = 4'h0;
    for (int i = 0; i < 9; i++) begin
      tick(path[i], 1'b0);
      if (bus.Capture_DR) cap_n++;
      if (bus.Shift_DR)   sh_n++;
      if (bus.Update_DR)  upd_n++;
    end
    chk4("cap_cycles", 4'(cap_n), 4'd1);
    chk4("shift_cycles", 4'(sh_n), 4'd1);
    chk4("upd_cycles", 4'(upd_n), 4'd1);
    chk4("path_end", bus.state, 4'hC ^ strobe_tms);

    // async reset in the middle of a DR shift
    load_ir(4'h2);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
    chk1("pre_rst_en", bus.TDO_en, 1'b1);
    TRST_n = 1'b0;
    #1;
    chk4("mid_rst_state", bus.state, 4'hF);
    chk1("mid_rst_en", bus.TDO_en, 1'b0);
    chk4("mid_rst_ir", bus.ir_out, 4'hF);
    chk1("mid_rst_sel", bus.sel_bypass, 1'b1);
    #1 TRST_n = 1'b1;
    tick(1'b0, 1'b0);
    chk4("post_rst_state", bus.state, 4'hC);
    chk4("post_rst_ir", bus.ir_out, 4'hF);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
